ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Consumes the 4-bit ALU opcode and Sign flag from the ALU control decoder, plus operands and control bits from decode.
- Contains the ID/EX pipeline register, the ALU datapath, signed-overflow detection and the EX/MEM pipeline register.
- Feeds the memory stage and the hazard/forwarding logic.

Parameters:
- DATA_W, 32, datapath width
- REG_ADDR_W, 5, register-file address width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- stall  in  1  hold ID/EX contents; insert a bubble into EX/MEM
- flush  in  1  replace ID/EX contents with a bubble
- id_valid  in  1  decode slot holds a real instruction
- id_alu_op  in  4  ALU operation code
- id_sign  in  1  signed-operation flag
- id_a  in  DATA_W  operand A (rs)
- id_b  in  DATA_W  operand B (rt or extended immediate)
- id_shamt  in  5  shift amount
- id_store_data  in  DATA_W  rt value for stores
- id_rd_addr  in  REG_ADDR_W  destination register
- id_reg_write, id_mem_read, id_mem_write  in  1 each  downstream controls
- ex_valid  out  1  EX/MEM holds a real instruction
- ex_result  out  DATA_W  registered ALU result
- ex_zero  out  1  registered (ALU result == 0)
- ex_overflow  out  1  registered signed-overflow flag
- ex_store_data  out  DATA_W  registered store data
- ex_rd_addr  out  REG_ADDR_W  registered destination register
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered controls, gated by valid and overflow

Behaviour:
- Reset (reset=0, asynchronous): both pipeline registers clear immediately; every output is 0. Reset mid-operation discards in-flight instructions. The first capture happens on the first rising edge after reset rises.
- Latency: an instruction presented on id_* at edge N appears on ex_* after edge N+1 (2 edges). Throughput is 1 per cycle when there is no stall or flush.
- ID/EX update priority, highest first:
  - flush: capture a bubble (valid=0, all controls 0, data 0).
  - stall: hold current contents.
  - otherwise: capture id_*.
- flush and stall together: flush wins.
- EX/MEM update:
  - Captures the ALU output of ID/EX every cycle, except during stall, when it captures a bubble.
  - A bubble in ID/EX produces a bubble in EX/MEM.
- ALU (combinational, on ID/EX contents):
  - 0 ADD: a+b
  - 1 SUB: a-b
  - 2 AND: a&b
  - 3 OR: a|b
  - 4 XOR: a^b
  - 5 NOR: ~(a|b)
  - 6 SL: b << shamt
  - 7 SR: b >> shamt; arithmetic if sign=1, logical if sign=0
  - 8 LT: (a<b) as 0/1; signed if sign=1, unsigned if sign=0
  - 9 LE: (a<=b), always signed
  - 10 GT: (a>b), always signed
  - 11–15: result 0
- Width rules: results truncate to DATA_W and comparison results are zero-extended. Only shamt[4:0] is used.
- Overflow:
  - Set only for ADD/SUB with sign=1, when both operands have the same sign (ADD) or different signs (SUB) and the result sign differs from a.
  - When set: ex_overflow=1, ex_reg_write=0, ex_mem_read=0, ex_mem_write=0; ex_result still holds the wrapped sum.
  - Unsigned ADD/SUB never flag overflow.
- ex_zero reflects the captured result, including wrapped values.
- Bubble: ex_result, ex_zero, ex_overflow and ex_store_data are 0, and all controls are 0.

Decomposition:
- Shared package holds:
  - ALU op constants ADD=0 … GT=10, 4-bit op type
  - DATA_W and REG_ADDR_W defaults
  - a bubble constant for the ID/EX record
- One combinational sub-module, alu_core (op, sign, a, b, shamt → result, overflow). ex_stage owns both register stages and the gating logic.

Test Plan:
- ADD sign=0, a=5, b=7, rd=3, reg_write=1 at edge N → after edge N+1: ex_result=12, ex_zero=0, ex_rd_addr=3, ex_reg_write=1, ex_valid=1.
- ADD sign=1, a=0x7FFFFFFF, b=1 → ex_result=0x80000000, ex_overflow=1, ex_reg_write=0. Same operands with sign=0 → ex_overflow=0, ex_reg_write=1.
- SR shamt=4, b=0x80000000: sign=1 → 0xF8000000; sign=0 → 0x08000000. LT a=0xFFFFFFFF, b=1: sign=1 → 1; sign=0 → 0.
- Stall held one cycle on instruction X → EX/MEM shows one bubble (ex_valid=0, ex_reg_write=0), then X appears exactly once. flush+stall in the same cycle → ID/EX becomes a bubble.
- Back-to-back instructions I1..I4, no stall → ex_* presents I1..I4 on consecutive cycles. SUB a=b=9 → ex_zero=1, ex_result=0.
- reset driven low mid-cycle with valid instructions in flight → all outputs 0 immediately, without waiting for a clock edge. After reset rises, the next captured instruction emerges 2 edges later.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared types for the execute stage: ALU opcodes, default widths, pipeline records.
// The record layouts are sized by the default widths below.
package ex_stage_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int SHAMT_W        = 5;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 4'd0;
    localparam alu_op_t ALU_SUB = 4'd1;
    localparam alu_op_t ALU_AND = 4'd2;
    localparam alu_op_t ALU_OR  = 4'd3;
    localparam alu_op_t ALU_XOR = 4'd4;
    localparam alu_op_t ALU_NOR = 4'd5;
    localparam alu_op_t ALU_SL  = 4'd6;
    localparam alu_op_t ALU_SR  = 4'd7;
    localparam alu_op_t ALU_LT  = 4'd8;
    localparam alu_op_t ALU_LE  = 4'd9;
    localparam alu_op_t ALU_GT  = 4'd10;

    typedef struct packed {
        logic                      valid;
        alu_op_t                   alu_op;
        logic                      sign;
        logic [DATA_W_DEF-1:0]     a;
        logic [DATA_W_DEF-1:0]     b;
        logic [SHAMT_W-1:0]        shamt;
        logic [DATA_W_DEF-1:0]     store_data;
        logic [REG_ADDR_W_DEF-1:0] rd_addr;
        logic                      reg_write;
        logic                      mem_read;
        logic                      mem_write;
    } idex_t;

    typedef struct packed {
        logic                      valid;
        logic [DATA_W_DEF-1:0]     result;
        logic                      zero;
        logic                      overflow;
        logic [DATA_W_DEF-1:0]     store_data;
        logic [REG_ADDR_W_DEF-1:0] rd_addr;
        logic                      reg_write;
        logic                      mem_read;
        logic                      mem_write;
    } exmem_t;

    localparam idex_t  IDEX_BUBBLE  = '0;
    localparam exmem_t EXMEM_BUBBLE = '0;

endpackage

// File: rtl/ex_stage_alu_core.sv
// ALU datapath with signed-overflow detection for ADD/SUB.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle on whatever ID/EX holds.
module alu_core
    import ex_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  alu_op_t             op,
    input  logic                sign,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [SHAMT_W-1:0]  shamt,
    output logic [DATA_W-1:0]   result,
    output logic                overflow
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0]        sum;
    logic [DATA_W-1:0]        diff;
    logic signed [DATA_W-1:0] sra;
    logic                     lt_s;
    logic                     lt_u;
    logic                     gt_s;

    assign sum  = a + b;
    assign diff = a - b;
    // kept as a separate signed net so the shift stays arithmetic
    assign sra  = $signed(b) >>> shamt;
    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;
    assign gt_s = $signed(a) > $signed(b);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (op)
            ALU_ADD: begin
                result   = sum;
                overflow = sign & (a[MSB] == b[MSB]) & (sum[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                result   = diff;
                overflow = sign & (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_SL:  result = b << shamt;
            ALU_SR:  result = sign ? sra : (b >> shamt);
            ALU_LT:  result = {{(DATA_W-1){1'b0}}, (sign ? lt_s : lt_u)};
            ALU_LE:  result = {{(DATA_W-1){1'b0}}, ~gt_s};
            ALU_GT:  result = {{(DATA_W-1){1'b0}}, gt_s};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, ALU, EX/MEM register with overflow gating.
// Latency: 2 edges from id_* to ex_*; 1 instruction per cycle.
// Backpressure: stall holds ID/EX and bubbles EX/MEM; flush bubbles ID/EX and wins over stall.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [3:0]            id_alu_op,
    input  logic                  id_sign,
    input  logic [DATA_W-1:0]     id_a,
    input  logic [DATA_W-1:0]     id_b,
    input  logic [4:0]            id_shamt,
    input  logic [DATA_W-1:0]     id_store_data,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_result,
    output logic                  ex_zero,
    output logic                  ex_overflow,
    output logic [DATA_W-1:0]     ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write
);

    idex_t             idex_in, idex_d, idex_q;
    exmem_t            exmem_d, exmem_q;
    logic [DATA_W-1:0] alu_result;
    logic              alu_ovf;

    always_comb begin
        idex_in            = IDEX_BUBBLE;
        idex_in.valid      = id_valid;
        idex_in.alu_op     = id_alu_op;
        idex_in.sign       = id_sign;
        idex_in.a          = id_a;
        idex_in.b          = id_b;
        idex_in.shamt      = id_shamt;
        idex_in.store_data = id_store_data;
        idex_in.rd_addr    = id_rd_addr;
        idex_in.reg_write  = id_reg_write;
        idex_in.mem_read   = id_mem_read;
        idex_in.mem_write  = id_mem_write;
    end

    always_comb begin
        idex_d = idex_q;
        if (flush)
            idex_d = IDEX_BUBBLE;
        else if (!stall)
            idex_d = idex_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) idex_q <= IDEX_BUBBLE;
        else        idex_q <= idex_d;
    end

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .op       (idex_q.alu_op),
        .sign     (idex_q.sign),
        .a        (idex_q.a),
        .b        (idex_q.b),
        .shamt    (idex_q.shamt),
        .result   (alu_result),
        .overflow (alu_ovf)
    );

    // An overflowing instruction keeps its wrapped result but loses every side effect.
    always_comb begin
        exmem_d = EXMEM_BUBBLE;
        if (!stall && idex_q.valid) begin
            exmem_d.valid      = 1'b1;
            exmem_d.result     = alu_result;
            exmem_d.zero       = (alu_result == '0);
            exmem_d.overflow   = alu_ovf;
            exmem_d.store_data = idex_q.store_data;
            exmem_d.rd_addr    = idex_q.rd_addr;
            exmem_d.reg_write  = idex_q.reg_write & ~alu_ovf;
            exmem_d.mem_read   = idex_q.mem_read  & ~alu_ovf;
            exmem_d.mem_write  = idex_q.mem_write & ~alu_ovf;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) exmem_q <= EXMEM_BUBBLE;
        else        exmem_q <= exmem_d;
    end

    assign ex_valid      = exmem_q.valid;
    assign ex_result     = exmem_q.result;
    assign ex_zero       = exmem_q.zero;
    assign ex_overflow   = exmem_q.overflow;
    assign ex_store_data = exmem_q.store_data;
    assign ex_rd_addr    = exmem_q.rd_addr;
    assign ex_reg_write  = exmem_q.reg_write;
    assign ex_mem_read   = exmem_q.mem_read;
    assign ex_mem_write  = exmem_q.mem_write;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed vector table, hand sequences, randomized pipeline vs. reference model.
module tb_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic        sign;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw, mr, mw;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw, mr, mw;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  e;
    } vec_t;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;
    localparam int     NVEC = 20;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        id_valid, id_sign, id_reg_write, id_mem_read, id_mem_write;
    logic [3:0]  id_alu_op;
    logic [31:0] id_a, id_b, id_store_data;
    logic [4:0]  id_shamt, id_rd_addr;
    logic        ex_valid, ex_zero, ex_overflow, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] ex_result, ex_store_data;
    logic [4:0]  ex_rd_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_alu_op(id_alu_op), .id_sign(id_sign),
        .id_a(id_a), .id_b(id_b), .id_shamt(id_shamt), .id_store_data(id_store_data),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .ex_valid(ex_valid), .ex_result(ex_result), .ex_zero(ex_zero),
        .ex_overflow(ex_overflow), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    function automatic in_t mk(input logic [3:0] op, input logic sign, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] shamt, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic mw, input logic [31:0] sd);
        in_t x;
        x.valid = 1'b1; x.op = op; x.sign = sign; x.a = a; x.b = b; x.shamt = shamt;
        x.rd = rd; x.rw = rw; x.mr = mr; x.mw = mw; x.sd = sd;
        return x;
    endfunction

    function automatic out_t mo(input logic [31:0] result, input logic zero, input logic ovf,
                                input logic [4:0] rd, input logic rw, input logic mr,
                                input logic mw, input logic [31:0] sd);
        out_t o;
        o.valid = 1'b1; o.result = result; o.zero = zero; o.ovf = ovf;
        o.rd = rd; o.rw = rw; o.mr = mr; o.mw = mw; o.sd = sd;
        return o;
    endfunction

    // Reference: evaluates the instruction with 64-bit integer arithmetic.
    function automatic out_t model(input in_t x);
        out_t        o;
        longint      sa, sb, ua, ub, full, p, q;
        logic [31:0] r;
        logic        ov;
        o = '0;
        if (!x.valid) return o;
        sa = $signed(x.a); sb = $signed(x.b);
        ua = {32'd0, x.a}; ub = {32'd0, x.b};
        p  = 64'sd1 << x.shamt;
        r  = 32'd0; ov = 1'b0; full = 0; q = 0;
        case (x.op)
            4'd0: begin full = x.sign ? sa + sb : ua + ub; r = full[31:0];
                        ov = x.sign && (full > MAXS || full < MINS); end
            4'd1: begin full = x.sign ? sa - sb : ua - ub; r = full[31:0];
                        ov = x.sign && (full > MAXS || full < MINS); end
            4'd2: r = x.a & x.b;
            4'd3: r = x.a | x.b;
            4'd4: r = x.a ^ x.b;
            4'd5: r = ~(x.a | x.b);
            4'd6: begin full = ub * p; r = full[31:0]; end
            4'd7: begin
                if (x.sign) begin
                    q = sb / p;
                    if (sb < 0 && (sb % p) != 0) q = q - 1;
                end else begin
                    q = ub / p;
                end
                r = q[31:0];
            end
            4'd8:  r = {31'd0, (x.sign ? (sa < sb) : (ua < ub))};
            4'd9:  r = {31'd0, (sa <= sb)};
            4'd10: r = {31'd0, (sa > sb)};
            default: r = 32'd0;
        endcase
        o.valid = 1'b1; o.result = r; o.zero = (r == 32'd0); o.ovf = ov;
        o.sd = x.sd; o.rd = x.rd;
        o.rw = x.rw && !ov; o.mr = x.mr && !ov; o.mw = x.mw && !ov;
        return o;
    endfunction

    function automatic out_t got();
        return {ex_valid, ex_result, ex_zero, ex_overflow, ex_store_data, ex_rd_addr,
                ex_reg_write, ex_mem_read, ex_mem_write};
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input in_t x);
        id_valid = x.valid; id_alu_op = x.op; id_sign = x.sign; id_a = x.a; id_b = x.b;
        id_shamt = x.shamt; id_store_data = x.sd; id_rd_addr = x.rd;
        id_reg_write = x.rw; id_mem_read = x.mr; id_mem_write = x.mw;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input out_t e);
        out_t g;
        g = got();
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s: got v=%0b res=%h z=%0b ovf=%0b sd=%h rd=%0d rw/mr/mw=%0b%0b%0b, expected v=%0b res=%h z=%0b ovf=%0b sd=%h rd=%0d rw/mr/mw=%0b%0b%0b",
                     nm, g.valid, g.result, g.zero, g.ovf, g.sd, g.rd, g.rw, g.mr, g.mw,
                     e.valid, e.result, e.zero, e.ovf, e.sd, e.rd, e.rw, e.mr, e.mw);
        end
    endtask

    initial begin
        vec_t vecs[NVEC];
        in_t  b0, xi, yi, zi, rx;
        in_t  seq[4];
        in_t  m_idex;
        out_t m_ex;
        logic st, fl;

        b0 = '0;
        vecs[0]  = '{"add_u",      mk(4'd0, 0, 32'd5, 32'd7, 5'd0, 5'd3, 1, 0, 0, 32'h0), mo(32'd12, 0, 0, 5'd3, 1, 0, 0, 32'h0)};
        vecs[1]  = '{"add_s_ovf",  mk(4'd0, 1, 32'h7FFFFFFF, 32'd1, 5'd0, 5'd4, 1, 0, 0, 32'h11), mo(32'h80000000, 0, 1, 5'd4, 0, 0, 0, 32'h11)};
        vecs[2]  = '{"add_u_noovf",mk(4'd0, 0, 32'h7FFFFFFF, 32'd1, 5'd0, 5'd4, 1, 0, 0, 32'h22), mo(32'h80000000, 0, 0, 5'd4, 1, 0, 0, 32'h22)};
        vecs[3]  = '{"sra",        mk(4'd7, 1, 32'd0, 32'h80000000, 5'd4, 5'd5, 1, 0, 0, 32'h0), mo(32'hF8000000, 0, 0, 5'd5, 1, 0, 0, 32'h0)};
        vecs[4]  = '{"srl",        mk(4'd7, 0, 32'd0, 32'h80000000, 5'd4, 5'd5, 1, 0, 0, 32'h0), mo(32'h08000000, 0, 0, 5'd5, 1, 0, 0, 32'h0)};
        vecs[5]  = '{"lt_s",       mk(4'd8, 1, 32'hFFFFFFFF, 32'd1, 5'd0, 5'd6, 1, 0, 0, 32'h0), mo(32'd1, 0, 0, 5'd6, 1, 0, 0, 32'h0)};
        vecs[6]  = '{"lt_u",       mk(4'd8, 0, 32'hFFFFFFFF, 32'd1, 5'd0, 5'd6, 1, 0, 0, 32'h0), mo(32'd0, 1, 0, 5'd6, 1, 0, 0, 32'h0)};
        vecs[7]  = '{"sub_zero",   mk(4'd1, 0, 32'd9, 32'd9, 5'd0, 5'd7, 1, 0, 0, 32'h0), mo(32'd0, 1, 0, 5'd7, 1, 0, 0, 32'h0)};
        vecs[8]  = '{"sub_s_ovf",  mk(4'd1, 1, 32'h80000000, 32'd1, 5'd0, 5'd0, 0, 0, 1, 32'hDEADBEEF), mo(32'h7FFFFFFF, 0, 1, 5'd0, 0, 0, 0, 32'hDEADBEEF)};
        vecs[9]  = '{"sub_u_wrap", mk(4'd1, 0, 32'd0, 32'd1, 5'd0, 5'd9, 1, 1, 0, 32'h5), mo(32'hFFFFFFFF, 0, 0, 5'd9, 1, 1, 0, 32'h5)};
        vecs[10] = '{"and",        mk(4'd2, 0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 5'd10, 1, 0, 0, 32'h0), mo(32'hF000F000, 0, 0, 5'd10, 1, 0, 0, 32'h0)};
        vecs[11] = '{"or",         mk(4'd3, 0, 32'h12340000, 32'h00005678, 5'd0, 5'd11, 1, 0, 0, 32'h0), mo(32'h12345678, 0, 0, 5'd11, 1, 0, 0, 32'h0)};
        vecs[12] = '{"xor",        mk(4'd4, 0, 32'hFFFF0000, 32'hFF00FF00, 5'd0, 5'd12, 1, 0, 0, 32'h0), mo(32'h00FFFF00, 0, 0, 5'd12, 1, 0, 0, 32'h0)};
        vecs[13] = '{"nor",        mk(4'd5, 0, 32'd0, 32'd0, 5'd0, 5'd13, 1, 0, 0, 32'h0), mo(32'hFFFFFFFF, 0, 0, 5'd13, 1, 0, 0, 32'h0)};
        vecs[14] = '{"sl_31",      mk(4'd6, 0, 32'd0, 32'd3, 5'd31, 5'd14, 1, 0, 0, 32'h0), mo(32'h80000000, 0, 0, 5'd14, 1, 0, 0, 32'h0)};
        vecs[15] = '{"le_signed",  mk(4'd9, 0, 32'hFFFFFFFF, 32'd1, 5'd0, 5'd15, 1, 0, 0, 32'h0), mo(32'd1, 0, 0, 5'd15, 1, 0, 0, 32'h0)};
        vecs[16] = '{"gt_signed",  mk(4'd10, 0, 32'd1, 32'hFFFFFFFF, 5'd0, 5'd16, 1, 0, 0, 32'h0), mo(32'd1, 0, 0, 5'd16, 1, 0, 0, 32'h0)};
        vecs[17] = '{"gt_equal",   mk(4'd10, 1, 32'd5, 32'd5, 5'd0, 5'd17, 1, 0, 0, 32'h0), mo(32'd0, 1, 0, 5'd17, 1, 0, 0, 32'h0)};
        vecs[18] = '{"op15",       mk(4'd15, 0, 32'd5, 32'd7, 5'd3, 5'd18, 1, 1, 0, 32'h3), mo(32'd0, 1, 0, 5'd18, 1, 1, 0, 32'h3)};
        vecs[19] = '{"add_s_wrap0",mk(4'd0, 1, 32'h80000000, 32'h80000000, 5'd0, 5'd19, 1, 1, 1, 32'h7), mo(32'd0, 1, 1, 5'd19, 0, 0, 0, 32'h7)};

        // reset state, including across a clock edge with live inputs
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(vecs[0].i);
        #3 chk("reset_state", '0);
        step();
        chk("reset_held_edge", '0);
        @(negedge clk) reset = 1'b1;

        for (int k = 0; k < NVEC; k++) begin
            drive(vecs[k].i);
            step();
            drive(b0);
            step();
            chk(vecs[k].name, vecs[k].e);
        end

        // stall: one bubble, then X exactly once
        xi = mk(4'd0, 0, 32'd5, 32'd7, 5'd0, 5'd3, 1, 0, 0, 32'h0);
        yi = mk(4'd4, 0, 32'hAAAA, 32'h5555, 5'd0, 5'd8, 1, 0, 0, 32'h9);
        drive(xi); step();
        drive(yi); stall = 1'b1; step();
        chk("stall_bubble", '0);
        stall = 1'b0; drive(b0); step();
        chk("stall_release_x", mo(32'd12, 0, 0, 5'd3, 1, 0, 0, 32'h0));
        step();
        chk("stall_x_once", '0);

        // flush with stall: flush wins, held instruction is lost
        drive(xi); step();
        drive(yi); flush = 1'b1; stall = 1'b1; step();
        chk("flush_stall_bubble", '0);
        flush = 1'b0; stall = 1'b0; drive(b0); step();
        chk("flush_wins", '0);

        // flush alone: instruction already in ID/EX still reaches EX/MEM
        drive(xi); step();
        drive(yi); flush = 1'b1; step();
        chk("flush_passes_idex", model(xi));
        flush = 1'b0; drive(b0); step();
        chk("flush_bubble_out", '0);

        // back-to-back throughput
        seq[0] = mk(4'd0, 0, 32'd1, 32'd2, 5'd0, 5'd1, 1, 0, 0, 32'h1);
        seq[1] = mk(4'd1, 1, 32'd10, 32'd3, 5'd0, 5'd2, 1, 0, 0, 32'h2);
        seq[2] = mk(4'd3, 0, 32'hF0, 32'h0F, 5'd0, 5'd3, 0, 1, 0, 32'h3);
        seq[3] = mk(4'd6, 0, 32'd0, 32'd1, 5'd8, 5'd4, 0, 0, 1, 32'h4);
        for (int k = 0; k < 5; k++) begin
            drive(k < 4 ? seq[k] : b0);
            step();
            if (k >= 1) chk($sformatf("b2b_I%0d", k), model(seq[k-1]));
        end

        // asynchronous reset mid-cycle with work in flight
        zi = mk(4'd1, 1, 32'd100, 32'd58, 5'd0, 5'd21, 1, 0, 1, 32'hCAFE);
        drive(xi); step();
        drive(yi); step();
        chk("inflight_x", model(xi));
        #2 reset = 1'b0;
        #1 chk("async_reset", '0);
        @(negedge clk) reset = 1'b1;
        drive(zi);
        step();
        chk("post_reset_edge1", '0);
        drive(b0);
        step();
        chk("post_reset_edge2", model(zi));

        // randomized pipeline against the reference
        drive(b0); step(); step();
        m_idex = '0; m_ex = '0;
        for (int n = 0; n < 400; n++) begin
            rx.valid = ($urandom_range(0, 4) != 0);
            rx.op    = 4'($urandom_range(0, 15));
            rx.sign  = 1'($urandom_range(0, 1));
            rx.a     = pick32();
            rx.b     = pick32();
            rx.shamt = 5'($urandom_range(0, 31));
            rx.sd    = $urandom;
            rx.rd    = 5'($urandom_range(0, 31));
            rx.rw    = 1'($urandom_range(0, 1));
            rx.mr    = 1'($urandom_range(0, 1));
            rx.mw    = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 7) == 0);
            drive(rx); stall = st; flush = fl;
            step();
            m_ex   = st ? '0 : model(m_idex);
            m_idex = fl ? '0 : (st ? m_idex : rx);
            chk($sformatf("rand_%0d", n), m_ex);
        end
        stall = 1'b0; flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
